// File: rtl/river_log_scroller.sv
// River log scroller: per-row prescaled 1-pixel steps with wrap; log_x/log_moved are registered, 1-cycle latency after frame_tick.
// No backpressure. Optional speed-level feature enabled by defining LOG_SPEEDUP_EN (adds i_level_up).
module river_log_scroller #(
  parameter int NUM_ROWS = 4,
  parameter int SCREEN_W = 320,
  parameter int BASE_DIV = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_frame_tick,
  input  logic                   i_start,
  input  logic                   i_pause,
  input  logic                   i_restart,
`ifdef LOG_SPEEDUP_EN
  input  logic                   i_level_up,
`endif
  output logic [NUM_ROWS*10-1:0] o_log_x,
  output logic [NUM_ROWS-1:0]    o_log_moved,
  output logic [NUM_ROWS-1:0]    o_log_dir,
  output logic                   o_running
);
  localparam int CW      = $clog2(BASE_DIV*NUM_ROWS + 1);
  localparam int SPACING = SCREEN_W / NUM_ROWS;

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_HOLD} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_tick_en;
  logic [1:0] w_level;

`ifdef LOG_SPEEDUP_EN
  logic [1:0] r_level;

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_restart) begin
      r_level <= 2'd0;
    end else if (i_level_up && r_level != 2'd3) begin
      r_level <= r_level + 2'd1;
    end
  end

  assign w_level = r_level;
`else
  assign w_level = 2'd0;
`endif

  // A tick counts only while staying in RUN; entering or leaving RUN in the same cycle swallows it.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_en   = 1'b0;
    if (i_restart) begin
      w_state_nxt = ST_STOP;
    end else begin
      case (r_state)
        ST_STOP: if (i_start) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (i_pause) w_state_nxt = ST_HOLD;
          else         w_tick_en   = i_frame_tick;
        end
        ST_HOLD: if (!i_pause) w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_STOP;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= ST_STOP;
    else          r_state <= w_state_nxt;
  end

  assign o_running = (r_state == ST_RUN);

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
    localparam int         DIV = BASE_DIV * (g + 1);
    localparam logic [9:0] X0  = 10'(g * SPACING);
    localparam logic       DIR = ((g % 2) == 0);

    logic [9:0]    r_x;
    logic [CW-1:0] r_cnt;
    logic          r_moved;
    logic [CW-1:0] w_lim;
    logic          w_wrap;
    logic [9:0]    w_x_step;

    // Compare with >= so a level increase mid-count cannot strand the counter above the new limit.
    always_comb begin
      w_lim = '0;
      if (DIV > int'(w_level) + 1) w_lim = CW'(DIV - 1 - int'(w_level));
      w_wrap = (r_cnt >= w_lim);
      if (DIR) w_x_step = (r_x == 10'(SCREEN_W - 1)) ? 10'd0 : r_x + 10'd1;
      else     w_x_step = (r_x == 10'd0) ? 10'(SCREEN_W - 1) : r_x - 10'd1;
    end

    always_ff @(posedge i_clk) begin
      if (!i_reset || i_restart) begin
        r_x     <= X0;
        r_cnt   <= '0;
        r_moved <= 1'b0;
      end else begin
        r_moved <= 1'b0;
        if (w_tick_en) begin
          if (w_wrap) begin
            r_cnt   <= '0;
            r_x     <= w_x_step;
            r_moved <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end

    assign o_log_x[g*10 +: 10] = r_x;
    assign o_log_moved[g]      = r_moved;
    assign o_log_dir[g]        = DIR;
  end
endmodule

// File: tb/tb_river_log_scroller.sv
// Directed bench for river_log_scroller with default parameters; vector table plus wrap/pause/reset sequences.
module tb_river_log_scroller;
  logic        clk = 1'b0;
  logic        reset, frame_tick, start, pause, restart;
`ifdef LOG_SPEEDUP_EN
  logic        level_up;
`endif
  logic [39:0] log_x;
  logic [3:0]  log_moved, log_dir;
  logic        running;
  int          n_chk = 0;
  int          n_pass = 0;

  typedef struct {
    logic        ft;
    logic        st;
    logic        pa;
    logic        rs;
    logic [39:0] x;
    logic [3:0]  mv;
    logic        run;
  } vec_t;

  river_log_scroller dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_frame_tick (frame_tick),
    .i_start      (start),
    .i_pause      (pause),
    .i_restart    (restart),
`ifdef LOG_SPEEDUP_EN
    .i_level_up   (level_up),
`endif
    .o_log_x      (log_x),
    .o_log_moved  (log_moved),
    .o_log_dir    (log_dir),
    .o_running    (running)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] px(input int x3, input int x2, input int x1, input int x0);
    return {10'(x3), 10'(x2), 10'(x1), 10'(x0)};
  endfunction

  function automatic vec_t mk(input int ft, input int st, input int pa, input int rs,
                              input int x3, input int x2, input int x1, input int x0,
                              input int mv, input int run);
    vec_t v;
    v.ft  = (ft != 0);
    v.st  = (st != 0);
    v.pa  = (pa != 0);
    v.rs  = (rs != 0);
    v.x   = px(x3, x2, x1, x0);
    v.mv  = 4'(mv);
    v.run = (run != 0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input logic ft, input logic st, input logic pa, input logic rs);
    frame_tick = ft;
    start      = st;
    pause      = pa;
    restart    = rs;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    start      = 1'b0;
    restart    = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t vt [20];
    reset = 1'b0; frame_tick = 1'b0; start = 1'b0; pause = 1'b0; restart = 1'b0;
`ifdef LOG_SPEEDUP_EN
    level_up = 1'b0;
`endif
    //           ft st pa rs   x3  x2  x1 x0  mv run
    vt[0]  = mk(1, 1, 0, 0, 240, 160, 80, 0,  0, 1);
    vt[1]  = mk(1, 0, 0, 0, 240, 160, 80, 0,  0, 1);
    vt[2]  = mk(1, 0, 0, 0, 240, 160, 80, 1,  1, 1);
    vt[3]  = mk(0, 0, 0, 0, 240, 160, 80, 1,  0, 1);
    vt[4]  = mk(1, 0, 0, 0, 240, 160, 80, 1,  0, 1);
    vt[5]  = mk(1, 0, 0, 0, 240, 160, 79, 2,  3, 1);
    vt[6]  = mk(0, 1, 0, 0, 240, 160, 79, 2,  0, 1);
    vt[7]  = mk(1, 0, 1, 0, 240, 160, 79, 2,  0, 0);
    vt[8]  = mk(1, 0, 1, 0, 240, 160, 79, 2,  0, 0);
    vt[9]  = mk(1, 1, 1, 0, 240, 160, 79, 2,  0, 0);
    vt[10] = mk(1, 0, 0, 0, 240, 160, 79, 2,  0, 1);
    vt[11] = mk(1, 0, 0, 0, 240, 160, 79, 2,  0, 1);
    vt[12] = mk(1, 0, 0, 0, 240, 161, 79, 3,  5, 1);
    vt[13] = mk(1, 0, 0, 0, 240, 161, 79, 3,  0, 1);
    vt[14] = mk(1, 0, 0, 0, 239, 161, 78, 4, 11, 1);
    vt[15] = mk(1, 1, 0, 1, 240, 160, 80, 0,  0, 0);
    vt[16] = mk(1, 0, 0, 0, 240, 160, 80, 0,  0, 0);
    vt[17] = mk(0, 1, 0, 0, 240, 160, 80, 0,  0, 1);
    vt[18] = mk(1, 0, 0, 0, 240, 160, 80, 0,  0, 1);
    vt[19] = mk(1, 0, 0, 0, 240, 160, 80, 1,  1, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_x", log_x, px(240, 160, 80, 0));
    chk("reset_running", 40'(running), 40'd0);
    chk("reset_moved", 40'(log_moved), 40'd0);
    chk("reset_dir", 40'(log_dir), 40'h5);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cyc(vt[i].ft, vt[i].st, vt[i].pa, vt[i].rs);
      chk($sformatf("v%0d_x", i), log_x, vt[i].x);
      chk($sformatf("v%0d_moved", i), 40'(log_moved), 40'(vt[i].mv));
      chk($sformatf("v%0d_running", i), 40'(running), 40'(vt[i].run));
    end

    // Wrap-around in both directions from a clean restart.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(320);
    chk("lwrap_row1_zero", 40'(log_x[19:10]), 40'd0);
    ticks(4);
    chk("lwrap_row1_319", 40'(log_x[19:10]), 40'd319);
    chk("lwrap_moved1", 40'(log_moved[1]), 40'd1);
    ticks(314);
    chk("rwrap_row0_319", 40'(log_x[9:0]), 40'd319);
    ticks(2);
    chk("rwrap_row0_zero", 40'(log_x[9:0]), 40'd0);
    chk("rwrap_moved0", 40'(log_moved[0]), 40'd1);
    chk("t640_x", log_x, px(160, 266, 240, 0));
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("moved_one_cycle", 40'(log_moved), 40'd0);

    // Pause freezes everything; restart with a coincident tick reloads and stops.
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("pause_x", log_x, px(160, 266, 240, 0));
    chk("pause_running", 40'(running), 40'd0);
    chk("pause_moved", 40'(log_moved), 40'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("restart_x", log_x, px(240, 160, 80, 0));
    chk("restart_running", 40'(running), 40'd0);
    chk("restart_moved", 40'(log_moved), 40'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("stop_ignores_tick", log_x, px(240, 160, 80, 0));

    // Reset asserted mid-run overrides start and frame_tick.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    chk("pre_reset_row0", 40'(log_x[9:0]), 40'd1);
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("midrun_reset_x", log_x, px(240, 160, 80, 0));
    chk("midrun_reset_running", 40'(running), 40'd0);
    chk("midrun_reset_moved", 40'(log_moved), 40'd0);
    chk("midrun_reset_dir", 40'(log_dir), 40'h5);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_reset_stop", 40'(running), 40'd0);

`ifdef LOG_SPEEDUP_EN
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      level_up = 1'b1;
      @(posedge clk);
      #1;
      level_up = 1'b0;
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(4);
    chk("speed_row0", 40'(log_x[9:0]), 40'd4);
    chk("speed_row3_hold", 40'(log_x[39:30]), 40'd240);
    ticks(1);
    chk("speed_row3_step", 40'(log_x[39:30]), 40'd239);
    chk("speed_moved3", 40'(log_moved[3]), 40'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/river_log_scroller.md
RIVER_LOG_SCROLLER -- requirements
Module: river_log_scroller

Interface
REQ-001 The module SHALL have parameter NUM_ROWS, default 4, giving the number of river rows, with one log per row.
REQ-002 The module SHALL have parameter SCREEN_W, default 320, giving the pixel width of the horizontal wrap domain.
REQ-003 The module SHALL have parameter BASE_DIV, default 2, such that row r steps once every BASE_DIV*(r+1) frame ticks.
REQ-004 Port clk, input, 1 bit: the single clock; one clock domain; all state SHALL be updated on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 Port frame_tick, input, 1 bit: one-cycle pulse, once per video frame.
REQ-007 Port start, input, 1 bit: pulse that begins scrolling.
REQ-008 Port pause, input, 1 bit: level; while high, scrolling is frozen.
REQ-009 Port restart, input, 1 bit: pulse that reloads initial positions and stops scrolling.
REQ-010 Port log_x, output, NUM_ROWS*10 bits: the left edge of row r occupies bits [r*10+9 : r*10].
REQ-011 Port log_moved, output, NUM_ROWS bits: bit r is a one-cycle pulse in the cycle row r's new log_x first appears.
REQ-012 Port log_dir, output, NUM_ROWS bits: bit r is 1 for rightward motion; even rows SHALL be 1 and odd rows 0 (constant).
REQ-013 Port running, output, 1 bit: high in the RUN state only.

Function
REQ-014 The FSM SHALL have states STOP, RUN and HOLD.
REQ-015 The FSM transitions SHALL be: STOP->RUN on start; RUN->HOLD when pause=1; HOLD->RUN when pause=0; any state->STOP on restart.
REQ-016 restart SHALL take priority over start, pause and frame_tick in the same cycle.
REQ-017 Each row SHALL have a prescaler counter, 0..DIV_r-1, where DIV_r = BASE_DIV*(r+1).
REQ-018 The prescalers SHALL advance only on frame_tick while in RUN.
REQ-019 On a frame_tick in RUN with the row's counter at DIV_r-1, the counter SHALL clear and the row SHALL step by 1 pixel; otherwise the counter SHALL increment.
REQ-020 A step SHALL be registered, so that the new log_x and its log_moved pulse are visible in the cycle after the frame_tick cycle (latency 1).
REQ-021 The rightward step SHALL be x = (x == SCREEN_W-1) ? 0 : x+1.
REQ-022 The leftward step SHALL be x = (x == 0) ? SCREEN_W-1 : x-1.
REQ-023 log_x SHALL never leave the range 0..SCREEN_W-1.
REQ-024 In STOP and HOLD, frame_tick SHALL be ignored, and the counters, log_x and log_moved=0 SHALL hold.
REQ-025 A frame_tick in the same cycle as a RUN->HOLD transition SHALL be ignored.
REQ-026 A frame_tick in the same cycle as a STOP->RUN transition SHALL be ignored; counting begins with the next tick.
REQ-027 restart SHALL load the initial positions, clear all counters, and force log_moved=0 in the next cycle.
REQ-028 The initial position of row r SHALL be r*(SCREEN_W/NUM_ROWS), using integer division.
REQ-029 start in RUN or HOLD SHALL have no effect.

Reset
REQ-030 While reset=0 at a clock edge, the state SHALL become STOP, the counters 0, log_x the initial positions, log_moved 0 and running 0.
REQ-031 Reset SHALL override every other input, including a reset asserted mid-run.
REQ-032 log_dir SHALL be constant and unaffected by reset.

Configuration
REQ-033 When LOG_SPEEDUP_EN is defined, the module SHALL add a 1-bit input level_up and a 2-bit speed-level register, reset to 0 and cleared by restart.
REQ-034 Each level_up pulse SHALL increment the speed level, saturating at 3.
REQ-035 With LOG_SPEEDUP_EN defined, the effective divider SHALL be max(1, DIV_r - level), sampled when the counter wraps.
REQ-036 When LOG_SPEEDUP_EN is undefined, the level_up port and the level register SHALL be absent, and the behaviour SHALL equal level fixed at 0.

Verification
REQ-037 Reset and initial values: with the defaults, hold reset=0 for 2 cycles -> log_x = {240,160,80,0} (rows 3..0), running=0, log_moved=0.
REQ-038 Basic stepping: pulse start, then issue 2 frame_ticks -> the cycle after the 2nd tick has row0=1 and log_moved=4'b0001, with row1 still 80; after 4 ticks row1=79 and log_moved[1]=1.
REQ-039 Wrap-around: issue 638 ticks -> row0 reaches 319; 2 more ticks -> row0=0.
REQ-040 Left wrap-around: issue 320 ticks -> row1=0; 4 more ticks -> row1=319.
REQ-041 Pause and restart: in RUN, set pause=1 and issue 10 ticks -> no log_x change and running=0; clear pause, then pulse restart together with frame_tick -> next cycle log_x = initial positions, state STOP, no log_moved.
REQ-042 Speed-up (LOG_SPEEDUP_EN defined): issue 3 level_up pulses, then 4 ticks -> row0 steps every tick (DIV=max(1,2-3)=1) and row3 steps every 5 ticks.
